// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: sequencer state
// encodings and the helper that sizes the bit-index counter.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to count 0..w-1 (w is always at least 2).
    function automatic int idx_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit combinational full adder, time-shared by the serial sequencer.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Sum and majority carry.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell, LSB first, one bit
// per clock. Operands are latched on start; the result, carry-out and signed
// overflow are presented with a one-cycle done pulse WIDTH+1 cycles later.
// Optional feature macro: SERIAL_ADDSUB_OVF_EN (signed overflow output and its
// carry-into-MSB register; overflow reads 0 when undefined).
module serial_addsub_ctrl
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int IW = idx_width(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             cmsb_q, cmsb_d;
`endif

    logic fa_sum;
    logic fa_co;

    fa_cell u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_co)
    );

    // Next-state, datapath shifting and registered-output decode.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
        cmsb_d   = cmsb_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert B, seed carry with 1.
                    a_d      = a;
                    b_d      = op_sub ? ~b : b;
                    carry_d  = op_sub;
                    idx_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
                    cmsb_d   = 1'b0;
`endif
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                result_d = {fa_sum, result_q[WIDTH-1:1]};
                carry_d  = fa_co;
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                idx_d    = idx_q + IW'(1);
                if (idx_q == LAST_IDX) begin
                    // Final bit: carry_q is the carry into the MSB.
`ifdef SERIAL_ADDSUB_OVF_EN
                    cmsb_d = carry_q;
`endif
                    cout_d  = fa_co;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            cmsb_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_ADDSUB_OVF_EN
            cmsb_q   <= cmsb_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    // Both terms are flops, so overflow has no path from any input.
    assign overflow = cmsb_q ^ cout_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl (WIDTH=8): arithmetic vectors, latency,
// ignored start during RUN, mid-operation reset and back-to-back operation.
module tb_serial_addsub_ctrl;

    localparam int W = 8;
`ifdef SERIAL_ADDSUB_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         op_sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;

    int n_checks = 0;
    int n_fail   = 0;

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_sub   (op_sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation from IDLE and check latency, pulse width and results.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic sub, input logic [W-1:0] exp_r, input logic exp_c,
                          input logic exp_o);
        int n;
        @(negedge clk);
        a = av; b = bv; op_sub = sub; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; a = ~av; b = ~bv; op_sub = ~sub;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) check({tag, " busy"}, 32'(busy), 32'd1);
            if (done) break;
        end
        check({tag, " latency"}, 32'(n), 32'd9);
        check({tag, " result"}, 32'(result), 32'(exp_r));
        check({tag, " cout"}, 32'(cout), 32'(exp_c));
        check({tag, " ovf"}, 32'(overflow), 32'(exp_o & OVF_ON));
        @(negedge clk);
        check({tag, " done width"}, 32'(done), 32'd0);
        check({tag, " held"}, 32'(result), 32'(exp_r));
        $display("op %s: a=0x%02h b=0x%02h sub=%0d -> result=0x%02h cout=%0d ovf=%0d",
                 tag, av, bv, sub, result, cout, overflow);
    endtask

    initial begin
        int dones;
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst result", 32'(result), 32'd0);
        check("rst cout", 32'(cout), 32'd0);
        check("rst ovf", 32'(overflow), 32'd0);
        rst = 1'b0;

        run_op("add35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
        run_op("addff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("add7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("sub10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        run_op("sub80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Second start during RUN must be ignored; operand changes have no effect.
        @(negedge clk);
        a = 8'h35; b = 8'h4A; op_sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dones = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 3) begin a = 8'h01; b = 8'h01; op_sub = 1'b1; start = 1'b1; end
            if (c == 6) start = 1'b0;
            if (done) begin
                dones++;
                check("ign latency", 32'(c), 32'd9);
                check("ign result", 32'(result), 32'h7F);
            end
        end
        check("ign done count", 32'(dones), 32'd1);
        $display("op ignore_start: dones=%0d result=0x%02h", dones, result);

        // Reset at RUN cycle 4 aborts with no done pulse.
        @(negedge clk);
        a = 8'h35; b = 8'h4A; op_sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort result", 32'(result), 32'd0);
        rst = 1'b0;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort no done", 32'(dones), 32'd0);
        $display("op abort: busy=%0d done=%0d result=0x%02h", busy, done, result);
        run_op("add02_03", 8'h02, 8'h03, 1'b0, 8'h05, 1'b0, 1'b0);

        // Back-to-back: start held high accepts every 10 cycles.
        @(negedge clk);
        a = 8'h35; b = 8'h4A; op_sub = 1'b0; start = 1'b1;
        @(posedge clk);
        n = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            check($sformatf("b2b done c%0d", c), 32'(done), 32'((c % 10) == 9));
            if (done) begin
                n++;
                check($sformatf("b2b result %0d", n), 32'(result), 32'h7F);
                $display("op b2b #%0d: cycle=%0d result=0x%02h", n, c, result);
            end
        end
        start = 1'b0;
        check("b2b count", 32'(n), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_addsub_ctrl.md
# serial_addsub_ctrl

Bit-serial add/subtract sequencer that time-shares one full-adder cell across all operand bits, LSB first, one bit per clock. It sits beside the adder/subtractor cells in the arithmetic library. Area-constrained designs use it in place of a WIDTH-bit ripple adder/subtractor. It latches operands on a start handshake, runs WIDTH bit-cycles and then presents the result, carry/borrow-out and signed overflow with a one-cycle done pulse.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only in IDLE
- op_sub  input  1  0 = a+b, 1 = a−b; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, result valid
- result  output  WIDTH  sum/difference; held until next accepted start
- cout  output  1  carry-out of MSB (for sub: 1 = no borrow, a ≥ b unsigned)
- overflow  output  1  signed overflow of the operation

## Operation
- Reset: state=IDLE, busy=0, done=0, result=0, cout=0, overflow=0, bit index=0, carry=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: on start=1, latch a into the A shift register, latch b (inverted when op_sub=1) into the B shift register, set carry=op_sub, set index=0, go to RUN. Clear result on acceptance.
- RUN: each cycle, feed A[0], B[0] and carry into the full-adder cell. Shift the sum bit into the result MSB and shift result right. Register carry = cell carry-out. Shift A and B right. Increment index.
- RUN, at index=WIDTH−1: capture carry-into-MSB (pre-update carry) for overflow, then go to DONE.
- DONE: done=1 for exactly one cycle. cout = final carry. overflow = carry-into-MSB XOR final carry. Return to IDLE.
- start in RUN or DONE is ignored (no queueing). a, b and op_sub may change freely after acceptance.
- Arithmetic is modulo 2^WIDTH. Subtraction is a + ~b + 1.
- Reset mid-operation: abort immediately to reset values. No done pulse.

## Timing
- Cycle 0: start sampled high in IDLE.
- Cycles 1..WIDTH: RUN, busy=1.
- Cycle WIDTH+1: DONE, done=1, busy=0, result/cout/overflow valid.
- Total latency: start to done = WIDTH+1 cycles.
- Earliest next accept: start high in cycle WIDTH+2 (IDLE). Throughput is one operation per WIDTH+2 cycles.
- result, cout and overflow stay stable from DONE until the next accepted start.
- Outputs are registered. No combinational path from inputs to outputs.

## Configuration
- SERIAL_ADDSUB_OVF_EN defined: overflow computed as above, and the carry-into-MSB register is present.
- SERIAL_ADDSUB_OVF_EN undefined: overflow tied to 0, and the carry-into-MSB register is removed. All other behaviour is identical.

## Structure
- Shared package serial_arith_pkg holds:
  - state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - the index width function (clog2 of WIDTH)
- One sub-module, fa_cell: combinational full adder (a, b, cin → sum, cout), instantiated once.
- Top level holds the FSM, the shift registers, the index counter and the carry register.

## Test plan
- WIDTH=8, add 0x35+0x4A → result 0x7F, cout 0, overflow 0. done is exactly 9 cycles after start.
- Add 0xFF+0x01 → result 0x00, cout 1, overflow 0. Add 0x7F+0x01 → result 0x80, cout 0, overflow 1 (0 with SERIAL_ADDSUB_OVF_EN undefined).
- Sub 0x10−0x20 → result 0xF0, cout 0 (borrow), overflow 0. Sub 0x80−0x01 → result 0x7F, cout 1, overflow 1.
- Second start (0x01+0x01) asserted during RUN of 0x35+0x4A → ignored. Single done with 0x7F. Changing a/b mid-RUN does not affect result.
- rst asserted at RUN cycle 4 → next cycle busy=0, done=0, result=0. No done pulse. A fresh start then completes normally (0x02+0x03 → 0x05).
- Back-to-back: start held high continuously → accepts every 10 cycles. done pulses one cycle wide, each with the correct result.
